adma_axi_slv_mem: RTL and testbench



---
 rtl/adma_axi_slv_mem.sv | 196 +++++++++++++++++++
 tb/tb_adma_axi_slv_mem.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/adma_axi_slv_mem.sv
// adma_axi_slv_mem: AXI4 slave memory with independent read/write burst engines; ADMA_SLV_WLAST_CHK_EN enables wlast checking
module adma_axi_slv_mem #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 32,
  parameter int MEM_DEPTH = 256,
  parameter int MST_ID_W = 5,
  parameter int ATX_LEN_W = 8,
  parameter int ATX_RESP_W = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [MST_ID_W-1:0]   s_awid_i,
  input  logic [ADDR_W-1:0]     s_awaddr_i,
  input  logic [ATX_LEN_W-1:0]  s_awlen_i,
  input  logic [1:0]            s_awburst_i,
  input  logic                  s_awvalid_i,
  output logic                  s_awready_o,
  input  logic [DATA_W-1:0]     s_wdata_i,
  input  logic                  s_wlast_i,
  input  logic                  s_wvalid_i,
  output logic                  s_wready_o,
  output logic [MST_ID_W-1:0]   s_bid_o,
  output logic [ATX_RESP_W-1:0] s_bresp_o,
  output logic                  s_bvalid_o,
  input  logic                  s_bready_i,
  input  logic [MST_ID_W-1:0]   s_arid_i,
  input  logic [ADDR_W-1:0]     s_araddr_i,
  input  logic [ATX_LEN_W-1:0]  s_arlen_i,
  input  logic [1:0]            s_arburst_i,
  input  logic                  s_arvalid_i,
  output logic                  s_arready_o,
  output logic [MST_ID_W-1:0]   s_rid_o,
  output logic [DATA_W-1:0]     s_rdata_o,
  output logic [ATX_RESP_W-1:0] s_rresp_o,
  output logic                  s_rlast_o,
  output logic                  s_rvalid_o,
  input  logic                  s_rready_i
);
  localparam int SH = $clog2(DATA_W / 8);
  localparam int IW = $clog2(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W / 8);
  localparam logic [ATX_RESP_W-1:0] OKAY = '0;
  localparam logic [ATX_RESP_W-1:0] SLVERR = ATX_RESP_W'(2);
  localparam logic [ATX_RESP_W-1:0] DECERR = ATX_RESP_W'(3);
  typedef enum logic {R_IDLE, R_DATA} r_st_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_st_e;
  function automatic logic [ATX_RESP_W-1:0] beat_resp(input logic [ADDR_W-1:0] a, input logic [1:0] b);
    logic [ADDR_W:0] o;
    o = {1'b0, a} - {1'b0, BASE_ADDR};
    return b[1] ? SLVERR : (o[ADDR_W] || (o[ADDR_W-1:0] >> SH) >= ADDR_W'(MEM_DEPTH)) ? DECERR : OKAY;
  endfunction
  function automatic logic [IW-1:0] widx(input logic [ADDR_W-1:0] a);
    return IW'((a - BASE_ADDR) >> SH);
  endfunction
  function automatic logic [ATX_RESP_W-1:0] sev(input logic [ATX_RESP_W-1:0] a, input logic [ATX_RESP_W-1:0] b);
    return a > b ? a : b;
  endfunction
  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  r_st_e r_st_q;
  logic arready_q, rvalid_q, rlast_q;
  logic [MST_ID_W-1:0] rid_q;
  logic [DATA_W-1:0] rdata_q, r_data_d;
  logic [ATX_RESP_W-1:0] rresp_q, r_resp_d;
  logic [ADDR_W-1:0] r_addr_q, r_addr_d;
  logic [ATX_LEN_W-1:0] r_len_q, r_cnt_q;
  logic [1:0] r_burst_q, r_burst_d;
  w_st_e w_st_q;
  logic awready_q, wready_q, bvalid_q, w_end_d, mem_we;
  logic [MST_ID_W-1:0] bid_q;
  logic [ATX_RESP_W-1:0] bresp_q, w_beat_d, w_acc_d;
  logic [ADDR_W-1:0] w_addr_q;
  logic [ATX_LEN_W-1:0] w_len_q, w_cnt_q;
  logic [1:0] w_burst_q;
  assign s_arready_o = arready_q;
  assign s_rvalid_o = rvalid_q;
  assign s_rlast_o = rlast_q;
  assign s_rid_o = rid_q;
  assign s_rdata_o = rdata_q;
  assign s_rresp_o = rresp_q;
  assign s_awready_o = awready_q;
  assign s_wready_o = wready_q;
  assign s_bvalid_o = bvalid_q;
  assign s_bid_o = bid_q;
  assign s_bresp_o = bresp_q;
  // next read beat: the AR address when idle, otherwise the burst-advanced address
  always_comb begin
    r_addr_d = r_st_q == R_IDLE ? s_araddr_i : r_burst_q == 2'b01 ? r_addr_q + STEP : r_addr_q;
    r_burst_d = r_st_q == R_IDLE ? s_arburst_i : r_burst_q;
    r_resp_d = beat_resp(r_addr_d, r_burst_d);
    r_data_d = r_resp_d == OKAY ? mem_q[widx(r_addr_d)] : '0;
  end
  // read engine: loads a beat on AR and on every non-final R handshake
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      r_st_q <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q <= 1'b0;
      rlast_q <= 1'b0;
      rid_q <= '0;
      rdata_q <= '0;
      rresp_q <= '0;
      r_addr_q <= '0;
      r_len_q <= '0;
      r_burst_q <= '0;
      r_cnt_q <= '0;
    end else if (r_st_q == R_IDLE) begin
      if (s_arvalid_i) begin
        r_st_q <= R_DATA;
        arready_q <= 1'b0;
        rvalid_q <= 1'b1;
        rlast_q <= s_arlen_i == '0;
        rid_q <= s_arid_i;
        rdata_q <= r_data_d;
        rresp_q <= r_resp_d;
        r_addr_q <= r_addr_d;
        r_len_q <= s_arlen_i;
        r_burst_q <= s_arburst_i;
        r_cnt_q <= '0;
      end
    end else if (s_rready_i) begin
      if (rlast_q) begin
        r_st_q <= R_IDLE;
        arready_q <= 1'b1;
        rvalid_q <= 1'b0;
        rlast_q <= 1'b0;
      end else begin
        r_addr_q <= r_addr_d;
        r_cnt_q <= r_cnt_q + 1'b1;
        rdata_q <= r_data_d;
        rresp_q <= r_resp_d;
        rlast_q <= r_cnt_q + 1'b1 == r_len_q;
      end
    end
  // write beat decode, burst end and accumulated worst response
  always_comb begin
    w_beat_d = beat_resp(w_addr_q, w_burst_q);
    mem_we = wready_q && s_wvalid_i && w_beat_d == OKAY;
`ifdef ADMA_SLV_WLAST_CHK_EN
    w_end_d = w_cnt_q == w_len_q || s_wlast_i;
    w_acc_d = sev(sev(bresp_q, w_beat_d), s_wlast_i != (w_cnt_q == w_len_q) ? SLVERR : OKAY);
`else
    w_end_d = w_cnt_q == w_len_q;
    w_acc_d = sev(bresp_q, w_beat_d);
`endif
  end
`ifndef ADMA_SLV_WLAST_CHK_EN
  logic unused_wlast;
  assign unused_wlast = s_wlast_i;
`endif
  // write engine: AW accept, data beats, then hold B until accepted
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      w_st_q <= W_IDLE;
      awready_q <= 1'b1;
      wready_q <= 1'b0;
      bvalid_q <= 1'b0;
      bid_q <= '0;
      bresp_q <= '0;
      w_addr_q <= '0;
      w_len_q <= '0;
      w_burst_q <= '0;
      w_cnt_q <= '0;
    end else case (w_st_q)
      W_IDLE: if (s_awvalid_i) begin
        w_st_q <= W_DATA;
        awready_q <= 1'b0;
        wready_q <= 1'b1;
        bid_q <= s_awid_i;
        bresp_q <= OKAY;
        w_addr_q <= s_awaddr_i;
        w_len_q <= s_awlen_i;
        w_burst_q <= s_awburst_i;
        w_cnt_q <= '0;
      end
      W_DATA: if (s_wvalid_i) begin
        bresp_q <= w_acc_d;
        if (w_end_d) begin
          w_st_q <= W_RESP;
          wready_q <= 1'b0;
          bvalid_q <= 1'b1;
        end else begin
          w_addr_q <= w_burst_q == 2'b01 ? w_addr_q + STEP : w_addr_q;
          w_cnt_q <= w_cnt_q + 1'b1;
        end
      end
      default: if (s_bready_i) begin
        w_st_q <= W_IDLE;
        bvalid_q <= 1'b0;
        awready_q <= 1'b1;
      end
    endcase
  // memory array is never reset so contents survive areset
  always_ff @(posedge aclk)
    if (mem_we) mem_q[widx(w_addr_q)] <= s_wdata_i;
endmodule

// File: tb/tb_adma_axi_slv_mem.sv
// tb_adma_axi_slv_mem: directed vector bench for the AXI4 slave memory
module tb_adma_axi_slv_mem;
  typedef logic [255:0] w_t;
  typedef struct {
    logic wr;
    logic [31:0] addr;
    logic [7:0] len;
    logic [1:0] burst;
    logic [31:0] d0;
    int step;
    int ok;
    logic [1:0] resp;
  } vec_t;
  logic aclk = 1'b0, areset = 1'b1;
  logic [4:0] awid = '0, arid = '0, bid, rid;
  logic [31:0] awaddr = '0, araddr = '0;
  logic [7:0] awlen = '0, arlen = '0;
  logic [1:0] awburst = '0, arburst = '0, bresp, rresp;
  logic awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready, bvalid, bready = 1'b0;
  logic arvalid = 1'b0, arready, rlast, rvalid, rready = 1'b0;
  logic [255:0] wdata = '0, rdata;
  int nvec = 0, nerr = 0;
  vec_t v[$];
  always #5 aclk = ~aclk;
  adma_axi_slv_mem dut (
    .aclk(aclk), .areset(areset),
    .s_awid_i(awid), .s_awaddr_i(awaddr), .s_awlen_i(awlen), .s_awburst_i(awburst),
    .s_awvalid_i(awvalid), .s_awready_o(awready),
    .s_wdata_i(wdata), .s_wlast_i(wlast), .s_wvalid_i(wvalid), .s_wready_o(wready),
    .s_bid_o(bid), .s_bresp_o(bresp), .s_bvalid_o(bvalid), .s_bready_i(bready),
    .s_arid_i(arid), .s_araddr_i(araddr), .s_arlen_i(arlen), .s_arburst_i(arburst),
    .s_arvalid_i(arvalid), .s_arready_o(arready),
    .s_rid_o(rid), .s_rdata_o(rdata), .s_rresp_o(rresp), .s_rlast_o(rlast),
    .s_rvalid_o(rvalid), .s_rready_i(rready)
  );
  task automatic chk(input string nm, input w_t a, input w_t e);
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h", nm, a, e);
    end
  endtask
  task automatic do_read(input logic [4:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [31:0] d0, input int step,
                         input int ok, input logic [1:0] er);
    nvec++;
    @(negedge aclk);
    chk("arready", w_t'(arready), w_t'(1));
    arvalid = 1'b1; arid = id; araddr = addr; arlen = len; arburst = burst; rready = 1'b1;
    @(negedge aclk);
    arvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      chk("rvalid", w_t'(rvalid), w_t'(1));
      chk("rdata", rdata, i < ok ? w_t'(d0 + 32'(i * step)) : w_t'(0));
      chk("rresp", w_t'(rresp), i < ok ? w_t'(0) : w_t'(er));
      chk("rlast", w_t'(rlast), w_t'(i == int'(len)));
      chk("rid", w_t'(rid), w_t'(id));
      @(negedge aclk);
    end
    chk("rvalid_end", w_t'(rvalid), w_t'(0));
    chk("arready_end", w_t'(arready), w_t'(1));
  endtask
  task automatic do_write(input logic [4:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [31:0] d0, input int wl_at,
                          input int exp_beats, input logic [1:0] exp_resp);
    int beats = 0;
    nvec++;
    @(negedge aclk);
    chk("awready", w_t'(awready), w_t'(1));
    awvalid = 1'b1; awid = id; awaddr = addr; awlen = len; awburst = burst;
    @(negedge aclk);
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (!wready) break;
      wvalid = 1'b1; wdata = w_t'(d0 + 32'(i)); wlast = i == wl_at;
      beats++;
      @(negedge aclk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("wbeats", w_t'(beats), w_t'(exp_beats));
    chk("bvalid", w_t'(bvalid), w_t'(1));
    chk("bresp", w_t'(bresp), w_t'(exp_resp));
    chk("bid", w_t'(bid), w_t'(id));
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    chk("bvalid_end", w_t'(bvalid), w_t'(0));
    chk("awready_end", w_t'(awready), w_t'(1));
  endtask
  initial begin
    v.push_back('{1'b1, 32'h20,   8'd3,   2'b01, 32'h100, 0, 0, 2'b00});
    v.push_back('{1'b0, 32'h20,   8'd3,   2'b01, 32'h100, 1, 4, 2'b00});
    v.push_back('{1'b1, 32'h0,    8'd1,   2'b01, 32'hA0,  0, 0, 2'b00});
    v.push_back('{1'b0, 32'h0,    8'd1,   2'b01, 32'hA0,  1, 2, 2'b00});
    v.push_back('{1'b1, 32'h1FE0, 8'd0,   2'b01, 32'hFF0, 0, 0, 2'b00});
    v.push_back('{1'b0, 32'h1FE0, 8'd3,   2'b01, 32'hFF0, 1, 1, 2'b11});
    v.push_back('{1'b1, 32'hA0,   8'd3,   2'b00, 32'hD0,  0, 0, 2'b00});
    v.push_back('{1'b0, 32'hA0,   8'd0,   2'b01, 32'hD3,  0, 1, 2'b00});
    v.push_back('{1'b1, 32'hA0,   8'd1,   2'b10, 32'hEE,  0, 0, 2'b10});
    v.push_back('{1'b0, 32'hA0,   8'd1,   2'b00, 32'hD3,  0, 2, 2'b00});
    v.push_back('{1'b0, 32'hA0,   8'd1,   2'b10, 32'h0,   0, 0, 2'b10});
    v.push_back('{1'b1, 32'h1FE0, 8'd1,   2'b01, 32'h55,  0, 0, 2'b11});
    v.push_back('{1'b0, 32'h1FE0, 8'd0,   2'b01, 32'h55,  0, 1, 2'b00});
    v.push_back('{1'b0, 32'h2000, 8'd0,   2'b01, 32'h0,   0, 0, 2'b11});
    v.push_back('{1'b1, 32'h20,   8'd0,   2'b11, 32'h77,  0, 0, 2'b10});
    v.push_back('{1'b0, 32'h20,   8'd0,   2'b01, 32'hA1,  0, 1, 2'b00});
    v.push_back('{1'b1, 32'hE0,   8'd0,   2'b01, 32'h77,  0, 0, 2'b00});
    v.push_back('{1'b0, 32'h0,    8'd255, 2'b00, 32'hA0,  0, 256, 2'b00});
    @(negedge aclk);
    nvec++;
    chk("rst_arready", w_t'(arready), w_t'(1));
    chk("rst_awready", w_t'(awready), w_t'(1));
    chk("rst_wready", w_t'(wready), w_t'(0));
    chk("rst_rvalid", w_t'(rvalid), w_t'(0));
    chk("rst_rlast", w_t'(rlast), w_t'(0));
    chk("rst_bvalid", w_t'(bvalid), w_t'(0));
    chk("rst_rdata", rdata, w_t'(0));
    chk("rst_ids", w_t'({rid, bid, rresp, bresp}), w_t'(0));
    areset = 1'b0;
    for (int k = 0; k < v.size(); k++)
      if (v[k].wr) do_write(5'(k), v[k].addr, v[k].len, v[k].burst, v[k].d0, int'(v[k].len), int'(v[k].len) + 1, v[k].resp);
      else do_read(5'(k), v[k].addr, v[k].len, v[k].burst, v[k].d0, v[k].step, v[k].ok, v[k].resp);
    // same-cycle read/write of word 7 with a stalled read beat
    nvec++;
    @(negedge aclk);
    arvalid = 1'b1; arid = 5'd9; araddr = 32'hE0; arlen = 8'd1; arburst = 2'b00;
    awvalid = 1'b1; awid = 5'd9; awaddr = 32'hE0; awlen = 8'd0; awburst = 2'b01; rready = 1'b1;
    @(negedge aclk);
    arvalid = 1'b0; awvalid = 1'b0;
    chk("col_beat0", rdata, w_t'(32'h77));
    chk("col_wready", w_t'(wready), w_t'(1));
    wvalid = 1'b1; wdata = w_t'(32'h99); wlast = 1'b1;
    @(negedge aclk);
    wvalid = 1'b0; wlast = 1'b0; rready = 1'b0;
    chk("col_beat1", rdata, w_t'(32'h77));
    chk("col_rlast", w_t'(rlast), w_t'(1));
    chk("col_bvalid", w_t'(bvalid), w_t'(1));
    @(negedge aclk);
    chk("col_hold_v", w_t'(rvalid), w_t'(1));
    chk("col_hold_d", rdata, w_t'(32'h77));
    chk("col_hold_l", w_t'(rlast), w_t'(1));
    rready = 1'b1; bready = 1'b1;
    @(negedge aclk);
    rready = 1'b0; bready = 1'b0;
    chk("col_rvalid_end", w_t'(rvalid), w_t'(0));
    chk("col_bvalid_end", w_t'(bvalid), w_t'(0));
    do_read(5'd10, 32'hE0, 8'd0, 2'b01, 32'h99, 0, 1, 2'b00);
    // asynchronous reset in the middle of a read burst
    nvec++;
    @(negedge aclk);
    arvalid = 1'b1; arid = 5'd3; araddr = 32'h40; arlen = 8'd3; arburst = 2'b01; rready = 1'b1;
    @(negedge aclk);
    arvalid = 1'b0;
    chk("arst_pre", w_t'(rvalid), w_t'(1));
    @(negedge aclk);
    areset = 1'b1;
    #1;
    chk("arst_rvalid", w_t'(rvalid), w_t'(0));
    chk("arst_arready", w_t'(arready), w_t'(1));
    chk("arst_rlast", w_t'(rlast), w_t'(0));
    @(negedge aclk);
    areset = 1'b0; rready = 1'b0;
    do_read(5'd4, 32'h40, 8'd0, 2'b01, 32'h101, 0, 1, 2'b00);
    // wlast placed early, then wlast missing on the final beat
`ifdef ADMA_SLV_WLAST_CHK_EN
    do_write(5'd11, 32'h140, 8'd3, 2'b01, 32'h300, 1, 2, 2'b10);
    do_read(5'd12, 32'h140, 8'd1, 2'b01, 32'h300, 1, 2, 2'b00);
    do_write(5'd13, 32'h180, 8'd1, 2'b01, 32'h400, 255, 2, 2'b10);
`else
    do_write(5'd11, 32'h140, 8'd3, 2'b01, 32'h300, 1, 4, 2'b00);
    do_read(5'd12, 32'h140, 8'd3, 2'b01, 32'h300, 1, 4, 2'b00);
    do_write(5'd13, 32'h180, 8'd1, 2'b01, 32'h400, 255, 2, 2'b00);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
